// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - FSM state codes, SPI mode codes and counter-width helper for spi_master_ctrl
package spi_pkg;

    typedef logic [2:0] spi_state_t;

    localparam spi_state_t S_IDLE     = 3'd0;
    localparam spi_state_t S_LOAD     = 3'd1;
    localparam spi_state_t S_SETUP    = 3'd2;
    localparam spi_state_t S_TRANSFER = 3'd3;
    localparam spi_state_t S_HOLD     = 3'd4;

    // Mode codes are {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_CLK_DIV = 4;
    localparam int DEF_CS_GAP  = 2;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - SCLK divider: div_cnt, SCLK register, edge strobes and edge count
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int EW      = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          en,
    input  logic          idle_level,
    output logic          sclk,
    output logic          lead_stb,
    output logic          trail_stb,
    output logic [EW-1:0] edge_cnt
);

    localparam int DW = cnt_w(CLK_DIV);

    logic [DW-1:0] div_cnt;
    logic          tick;

    assign tick      = en && (div_cnt == DW'(CLK_DIV - 1));
    // Even edge count means SCLK is still at idle level, so the coming edge is leading
    assign lead_stb  = tick && !edge_cnt[0];
    assign trail_stb = tick && edge_cnt[0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
            sclk     <= 1'b0;
        end else if (!en) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
            sclk     <= idle_level;
        end else if (tick) begin
            div_cnt  <= '0;
            edge_cnt <= edge_cnt + 1'b1;
            sclk     <= ~sclk;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

    always @(posedge i_clk) begin
        assert (CLK_DIV >= 2) else $error("spi_clk_div: CLK_DIV must be 2 or more");
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master sequencer; define SPI_CONT_XFER_EN for back-to-back frames under one CS
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int CS_GAP  = DEF_CS_GAP
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_cpol,
    input  logic i_cpha,
    output logic o_load,
    output logic o_shift_en,
    output logic o_sample_en,
    output logic o_ic_phase,
    output logic o_sclk,
    output logic o_cs_n,
    output logic o_busy,
    output logic o_done
);

    localparam int GW = cnt_w(CS_GAP);
    localparam int BW = cnt_w(WIDTH + 1);
    localparam int EW = cnt_w(2 * WIDTH + 1);

    spi_state_t    state, nxt;
    logic [1:0]    mode_q;
    logic [GW-1:0] gap_cnt;
    logic [BW-1:0] bit_cnt;
    logic [EW-1:0] edge_cnt;
    logic          lead_stb, trail_stb, cs_n_q, done_q;
    logic          samp_lead, samp_trail, gap_last, last_edge, frame_end;
    logic          idle_level;

    assign idle_level = (state == S_IDLE) ? i_cpol : mode_q[1];

    spi_clk_div #(
        .CLK_DIV (CLK_DIV),
        .EW      (EW)
    ) u_clk_div (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .en         (state == S_TRANSFER),
        .idle_level (idle_level),
        .sclk       (o_sclk),
        .lead_stb   (lead_stb),
        .trail_stb  (trail_stb),
        .edge_cnt   (edge_cnt)
    );

    assign samp_lead  = (mode_q == MODE0) || (mode_q == MODE2);
    assign samp_trail = (mode_q == MODE1) || (mode_q == MODE3);
    assign gap_last   = gap_cnt == GW'(CS_GAP - 1);
    assign last_edge  = trail_stb && (edge_cnt == EW'(2 * WIDTH - 1));

    assign o_sample_en = (lead_stb && samp_lead) || (trail_stb && samp_trail);
    // cpha=0 puts the MSB out during LOAD, so the final trailing edge has nothing left to shift
    assign o_shift_en  = ((state == S_LOAD) && samp_lead) || (lead_stb && samp_trail)
                       || (trail_stb && samp_lead && !last_edge);

    assign frame_end = last_edge && ((bit_cnt == BW'(WIDTH))
                     || (o_sample_en && (bit_cnt == BW'(WIDTH - 1))));

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:     if (i_start) nxt = S_LOAD;
            S_LOAD:     nxt = S_SETUP;
            S_SETUP:    if (gap_last) nxt = S_TRANSFER;
            S_TRANSFER: if (frame_end) nxt = S_HOLD;
            S_HOLD: begin
                if (gap_last) begin
`ifdef SPI_CONT_XFER_EN
                    nxt = i_start ? S_LOAD : S_IDLE;
`else
                    nxt = S_IDLE;
`endif
                end
            end
            default:    nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_IDLE;
            mode_q  <= MODE0;
            gap_cnt <= '0;
            bit_cnt <= '0;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state  <= nxt;
            done_q <= (state == S_HOLD) && gap_last;
            // A HOLD->LOAD hop only exists for chained frames, where CS must stay asserted
            cs_n_q <= !((nxt == S_SETUP) || (nxt == S_TRANSFER) || (nxt == S_HOLD)
                        || ((nxt == S_LOAD) && (state == S_HOLD)));
            if ((state == S_IDLE) && i_start)
                mode_q <= {i_cpol, i_cpha};
            if (((state == S_SETUP) || (state == S_HOLD)) && !gap_last)
                gap_cnt <= gap_cnt + 1'b1;
            else
                gap_cnt <= '0;
            if (state == S_LOAD)
                bit_cnt <= '0;
            else if (o_sample_en)
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign o_load     = state == S_LOAD;
    assign o_busy     = state != S_IDLE;
    assign o_cs_n     = cs_n_q;
    assign o_done     = done_q;
    assign o_ic_phase = mode_q[0];

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - scoreboard bench for spi_master_ctrl with serializer/deserializer loopback
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic cpol = 1'b0;
    logic cpha = 1'b0;
    logic o_load, o_shift_en, o_sample_en, o_ic_phase, o_sclk, o_cs_n, o_busy, o_done;

    spi_master_ctrl #(.WIDTH(8), .CLK_DIV(2), .CS_GAP(2)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_cpol      (cpol),
        .i_cpha      (cpha),
        .o_load      (o_load),
        .o_shift_en  (o_shift_en),
        .o_sample_en (o_sample_en),
        .o_ic_phase  (o_ic_phase),
        .o_sclk      (o_sclk),
        .o_cs_n      (o_cs_n),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rx;
        int n_load;
        int n_sample;
        int n_shift;
        int n_toggle;
        int cs_low;
        int trail;
        int load_shift;
        int overlap;
        int first_edge;
        int sclk_load;
        int sclk_done;
        int done_cs_n;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // WIDTH=8, CLK_DIV=2, CS_GAP=2: CS low 2+32+2=36, first visible SCLK edge 5 cycles after LOAD
    function automatic exp_t mk_exp(input logic pol, input logic pha, input logic [7:0] data);
        exp_t e;
        e.rx         = int'(data);
        e.n_load     = 1;
        e.n_sample   = 8;
        e.n_shift    = 8;
        e.n_toggle   = 16;
        e.cs_low     = 36;
        e.trail      = pha ? 8 : 0;
        e.load_shift = pha ? 0 : 1;
        e.overlap    = 0;
        e.first_edge = 5;
        e.sclk_load  = int'(pol);
        e.sclk_done  = int'(pol);
        e.done_cs_n  = 1;
        return e;
    endfunction

    logic [7:0] tx_data = 8'h00;
    logic [7:0] sreg = 8'h00;
    logic [7:0] rx_word = 8'h00;
    logic       mosi = 1'b0;

    always @(posedge clk) begin
        if (o_load) begin
            if (o_shift_en) begin
                mosi <= tx_data[7];
                sreg <= {tx_data[6:0], 1'b0};
            end else begin
                sreg <= tx_data;
            end
        end else if (o_shift_en) begin
            mosi <= sreg[7];
            sreg <= {sreg[6:0], 1'b0};
        end
        if (o_sample_en)
            rx_word <= {rx_word[6:0], mosi};
    end

    int   a_load, a_sample, a_shift, a_toggle, a_cs_low, a_trail, a_load_shift, a_overlap;
    int   a_first, a_since, a_sclk_load;
    bit   a_first_seen;
    logic prev_sclk = 1'b0;

    task clear_acc();
        a_load = 0; a_sample = 0; a_shift = 0; a_toggle = 0; a_cs_low = 0;
        a_trail = 0; a_load_shift = 0; a_overlap = 0; a_first = -1; a_since = 0;
        a_sclk_load = 0; a_first_seen = 0;
    endtask

    initial clear_acc();

    always @(negedge clk) begin
        if (rst) begin
            clear_acc();
        end else begin
            if (o_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rx_word", int'(rx_word), mon_e.rx);
                    check("load_count", a_load, mon_e.n_load);
                    check("sample_count", a_sample, mon_e.n_sample);
                    check("shift_count", a_shift, mon_e.n_shift);
                    check("sclk_toggles", a_toggle, mon_e.n_toggle);
                    check("cs_low_cycles", a_cs_low, mon_e.cs_low);
                    check("trailing_samples", a_trail, mon_e.trail);
                    check("shift_in_load", a_load_shift, mon_e.load_shift);
                    check("shift_sample_overlap", a_overlap, mon_e.overlap);
                    check("first_edge_delay", a_first, mon_e.first_edge);
                    check("sclk_idle_at_load", a_sclk_load, mon_e.sclk_load);
                    check("sclk_at_done", int'(o_sclk), mon_e.sclk_done);
                    check("cs_n_at_done", int'(o_cs_n), mon_e.done_cs_n);
                end
                clear_acc();
            end
            if (o_load) begin
                a_load++;
                a_load_shift += int'(o_shift_en);
                a_sclk_load = int'(o_sclk);
                a_since = 0;
                a_first_seen = 0;
            end else begin
                a_since++;
            end
            if (o_sample_en) begin
                a_sample++;
                if (int'(o_sclk) != a_sclk_load) a_trail++;
            end
            if (o_shift_en) a_shift++;
            if (o_shift_en && o_sample_en) a_overlap++;
            if (!o_cs_n) a_cs_low++;
            if (!o_cs_n && (o_sclk != prev_sclk)) begin
                a_toggle++;
                if (!a_first_seen) a_first = a_since;
                a_first_seen = 1;
            end
        end
        prev_sclk = o_sclk;
    end

    task automatic launch(input logic pol, input logic pha, input logic [7:0] data,
                          input bit push, input bit hold, input exp_t e);
        @(negedge clk);
        cpol = pol;
        cpha = pha;
        tx_data = data;
        repeat (2) @(negedge clk);
        if (push) exp_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        check("load_after_start", int'(o_load), 1);
        if (!hold) begin
            start = 1'b0;
            cpol = ~pol;
            cpha = ~pha;
        end
    endtask

    task automatic wait_done(input int bound);
        int k;
        for (k = 0; k < bound; k++) begin
            @(negedge clk);
            if (o_done) break;
        end
        check("done_within_bound", int'(k < bound), 1);
    endtask

    initial begin
        exp_t e1, e2;
        int   n, gap;

        repeat (3) @(negedge clk);
        check("reset_outputs", int'({o_load, o_shift_en, o_sample_en, o_sclk,
                                     o_cs_n, o_busy, o_done, o_ic_phase}), 8'b0000_1000);
        rst = 1'b0;

        for (int m = 0; m < 4; m++) begin
            e1 = mk_exp(m[1], m[0], 8'hA5);
            launch(m[1], m[0], 8'hA5, 1, 0, e1);
            wait_done(200);
        end
        e1 = mk_exp(1'b0, 1'b1, 8'h3C);
        launch(1'b0, 1'b1, 8'h3C, 1, 0, e1);
        wait_done(200);

        e1 = mk_exp(1'b0, 1'b0, 8'hA5);
        launch(1'b0, 1'b0, 8'hA5, 0, 0, e1);
        n = 0;
        for (int k = 0; k < 100 && n < 4; k++) begin
            @(negedge clk);
            if (o_sample_en) n++;
        end
        check("abort_reached_bit4", n, 4);
        #2 rst = 1'b1;
        #1 check("abort_outputs", int'({o_cs_n, o_sclk, o_busy, o_done}), 4'b1000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        e1 = mk_exp(1'b0, 1'b0, 8'h96);
        launch(1'b0, 1'b0, 8'h96, 1, 0, e1);
        wait_done(200);

`ifndef SPI_CONT_XFER_EN
        e1 = mk_exp(1'b0, 1'b0, 8'hC3);
        launch(1'b0, 1'b0, 8'hC3, 1, 1, e1);
        exp_q.push_back(e1);
        wait_done(200);
        gap = 0;
        for (int k = 0; k < 20 && o_cs_n; k++) begin
            gap++;
            @(negedge clk);
            if (o_load) start = 1'b0;
        end
        start = 1'b0;
        check("cs_high_between_frames", int'(gap >= 1), 1);
        wait_done(200);
`else
        e1 = mk_exp(1'b0, 1'b0, 8'hA5);
        e1.done_cs_n = 0;
        e2 = mk_exp(1'b0, 1'b0, 8'hA5);
        e2.cs_low = 37;
        launch(1'b0, 1'b0, 8'hA5, 1, 1, e1);
        exp_q.push_back(e2);
        wait_done(200);
        start = 1'b0;
        wait_done(200);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
